// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: word/length widths, framer FSM
// encoding, the FIFO payload layout and the length-to-bit-count mapping.
package serial_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned BITCNT_W = 5;               // must hold 16
  localparam int unsigned FIFO_W   = WORD_W + LEN_W;  // {len, data}

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [WORD_W-1:0] data;
  } word_t;

  // Length field 0 stands for a full 16-bit word.
  function automatic logic [BITCNT_W-1:0] len_to_bits(input logic [LEN_W-1:0] len);
    return (len == '0) ? BITCNT_W'(WORD_W) : BITCNT_W'(len);
  endfunction

endpackage

// File: rtl/p2s_framer_if.sv
// Bus bundle between a word producer / serial consumer and p2s_framer.
//   in_data/in_len/in_valid : producer -> framer word handshake
//   in_ready                : framer -> producer, FIFO not full
//   ser_data/ser_enable     : serial bit stream and qualifier
//   len_out                 : length code of the word in flight
//   busy/done               : activity flag and per-word completion pulse
// slave is the framer side, master is the producer/consumer side.
interface p2s_framer_if;
  import serial_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic [LEN_W-1:0]  in_len;
  logic              in_valid;
  logic              in_ready;
  logic              ser_data;
  logic              ser_enable;
  logic [LEN_W-1:0]  len_out;
  logic              busy;
  logic              done;

  modport master (
    output in_data, in_len, in_valid,
    input  in_ready, ser_data, ser_enable, len_out, busy, done
  );

  modport slave (
    input  in_data, in_len, in_valid,
    output in_ready, ser_data, ser_enable, len_out, busy, done
  );

endinterface

// File: rtl/word_fifo.sv
// Synchronous FIFO holding {len, data} words for the framer.
//   clk, reset : clock, asynchronous active-high reset
//   push/wdata : write strobe and payload (ignored while full)
//   pop        : read strobe (ignored while empty); head_c shows the oldest entry
//   full/empty/count : registered occupancy status
module word_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_c,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nx;
  logic             do_push;
  logic             do_pop;

  // Qualified strobes and next occupancy; simultaneous push/pop leaves count unchanged.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    count_nx = count;
    if (do_push && !do_pop) begin
      count_nx = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_nx = count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nx;
      full  <= (count_nx == CNT_W'(DEPTH));
      empty <= (count_nx == '0);
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/p2s_framer.sv
// Parallel-to-serial framer: buffers {len, data} words and sends each one
// MSB-first (bit L-1 down to bit 0) with ser_enable high for L cycles,
// followed by GAP idle cycles. All bus outputs are registered.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : p2s_framer_if.slave (word handshake in, serial stream out)
module p2s_framer
  import serial_pkg::*;
#(
  parameter int unsigned GAP        = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  p2s_framer_if.slave     bus
);

  localparam int unsigned GAP_W = $clog2(GAP + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e              state;
  state_e              state_nx;
  logic [WORD_W-1:0]   shreg;
  logic [WORD_W-1:0]   shreg_nx;
  logic [BITCNT_W-1:0] bitcnt;
  logic [BITCNT_W-1:0] bitcnt_nx;
  logic [GAP_W-1:0]    gapcnt;
  logic [GAP_W-1:0]    gapcnt_nx;
  logic [LEN_W-1:0]    len_nx;
  logic [3:0]          bit_idx;
  logic                load;
  logic                push;
  logic                pop;
  logic                ser_data_nx;
  logic                ser_enable_nx;
  logic                done_nx;
  logic                busy_nx;
  logic                in_ready_nx;

  logic [FIFO_W-1:0]   head_raw_c;
  word_t               head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    cnt_nx;

  word_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wdata  ({bus.in_len, bus.in_data}),
    .pop    (pop),
    .head_c (head_raw_c),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign head = word_t'(head_raw_c);

  // Next state, counters and the next value of every registered output.
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    bitcnt_nx = bitcnt;
    gapcnt_nx = gapcnt;
    len_nx    = bus.len_out;
    load      = 1'b0;
    done_nx   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_SHIFT: begin
        if (bitcnt == BITCNT_W'(1)) begin
          state_nx  = ST_GAP;
          gapcnt_nx = GAP_W'(GAP);
          done_nx   = 1'b1;
        end else begin
          bitcnt_nx = bitcnt - BITCNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gapcnt == GAP_W'(1)) begin
          if (!fifo_empty) load = 1'b1;
          else             state_nx = ST_IDLE;
        end else begin
          gapcnt_nx = gapcnt - GAP_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // Pop the FIFO head straight into the shifter.
    if (load) begin
      state_nx  = ST_SHIFT;
      shreg_nx  = head.data;
      len_nx    = head.len;
      bitcnt_nx = len_to_bits(head.len);
    end

    pop  = load;
    push = bus.in_valid && !fifo_full;

    cnt_nx        = fifo_count + CNT_W'(push) - CNT_W'(pop);
    ser_enable_nx = (state_nx == ST_SHIFT);
    bit_idx       = 4'(bitcnt_nx - BITCNT_W'(1));
    ser_data_nx   = ser_enable_nx && shreg_nx[bit_idx];
    busy_nx       = (state_nx != ST_IDLE) || (cnt_nx != '0);
    in_ready_nx   = (cnt_nx != CNT_W'(FIFO_DEPTH));
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      shreg          <= '0;
      bitcnt         <= '0;
      gapcnt         <= '0;
      bus.ser_data   <= 1'b0;
      bus.ser_enable <= 1'b0;
      bus.len_out    <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.in_ready   <= 1'b1;
    end else begin
      state          <= state_nx;
      shreg          <= shreg_nx;
      bitcnt         <= bitcnt_nx;
      gapcnt         <= gapcnt_nx;
      bus.ser_data   <= ser_data_nx;
      bus.ser_enable <= ser_enable_nx;
      bus.len_out    <= len_nx;
      bus.busy       <= busy_nx;
      bus.done       <= done_nx;
      bus.in_ready   <= in_ready_nx;
    end
  end

endmodule

// File: tb/tb_p2s_framer.sv
// Self-checking bench for p2s_framer. The reference keeps a list of accepted
// words with their acceptance edge k and start edge s, where
// s = max(end of previous word incl. gap, k+1); every output at every cycle is
// derived from that list. A shift-left receiver rebuilds each word.
module tb_p2s_framer;
  import serial_pkg::*;

  localparam int TB_GAP   = 3;
  localparam int TB_DEPTH = 4;
  localparam int MAXW     = 512;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  p2s_framer_if bus ();

  p2s_framer #(
    .GAP        (TB_GAP),
    .FIFO_DEPTH (TB_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  // Reference word list.
  int          w_k    [MAXW];
  int          w_s    [MAXW];
  int          w_bits [MAXW];
  logic [15:0] w_data [MAXW];
  logic [3:0]  w_len  [MAXW];
  int          nw;
  int          prev_end;

  // Downstream deserializer model.
  logic [15:0] rx;
  int          rx_bits;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic model_ready(input int e);
    int occ;
    occ = 0;
    for (int j = 0; j < nw; j++)
      if (w_k[j] <= e && e < w_s[j]) occ++;
    return occ < TB_DEPTH;
  endfunction

  task automatic model_clear();
    nw       = 0;
    prev_end = 0;
    cyc      = 0;
    rx       = '0;
    rx_bits  = 0;
  endtask

  // Compare all outputs for the current cycle against the word list.
  task automatic check_cycle();
    logic        en, dat, dn, bsy;
    logic [3:0]  ln;
    logic [15:0] mask;
    int          occ, done_w;
    en = 1'b0; dat = 1'b0; dn = 1'b0; bsy = 1'b0; ln = 4'd0;
    occ = 0; done_w = -1;
    for (int j = 0; j < nw; j++) begin
      if (w_s[j] <= cyc && cyc < w_s[j] + w_bits[j]) begin
        en  = 1'b1;
        dat = w_data[j][w_bits[j] - 1 - (cyc - w_s[j])];
      end
      if (cyc == w_s[j] + w_bits[j]) begin
        dn     = 1'b1;
        done_w = j;
      end
      if (w_k[j] <= cyc && cyc < w_s[j] + w_bits[j] + TB_GAP) bsy = 1'b1;
      if (w_k[j] <= cyc && cyc < w_s[j]) occ++;
      if (w_s[j] <= cyc) ln = w_len[j];
    end
    check_val("ser_enable", 32'(bus.ser_enable), 32'(en));
    check_val("ser_data",   32'(bus.ser_data),   32'(dat));
    check_val("done",       32'(bus.done),       32'(dn));
    check_val("len_out",    32'(bus.len_out),    32'(ln));
    check_val("busy",       32'(bus.busy),       32'(bsy));
    check_val("in_ready",   32'(bus.in_ready),   32'(occ < TB_DEPTH));
    if (bus.ser_enable === 1'b1) begin
      rx = {rx[14:0], bus.ser_data};
      rx_bits++;
    end
    if (done_w >= 0) begin
      mask = 16'((32'h1 << w_bits[done_w]) - 1);
      check_val("rx_bits", 32'(rx_bits), 32'(w_bits[done_w]));
      check_val("rx_data", 32'(rx & mask), 32'(w_data[done_w] & mask));
      rx      = '0;
      rx_bits = 0;
    end
  endtask

  // One clock: drive inputs, record acceptance in the model, check after the edge.
  task automatic cycle(input logic v, input logic [15:0] d, input logic [3:0] l, output logic acc);
    int k;
    acc = v && model_ready(cyc);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_len   = l;
    if (acc && nw < MAXW) begin
      k          = cyc + 1;
      w_k[nw]    = k;
      w_s[nw]    = (prev_end > k + 1) ? prev_end : k + 1;
      w_bits[nw] = (l == 4'd0) ? 16 : int'(l);
      w_data[nw] = d;
      w_len[nw]  = l;
      prev_end   = w_s[nw] + w_bits[nw] + TB_GAP;
      nw++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, acc);
  endtask

  initial begin
    logic acc;
    int   cnt;
    int   guard;
    int   base;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_len   = '0;
    model_clear();

    // Values held in reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cycle();
    reset = 1'b0;
    check_cycle();

    // Full 16-bit word, short word, single-bit word.
    cycle(1'b1, 16'hA5C3, 4'd0, acc);
    idle(25);
    cycle(1'b1, 16'hFFF9, 4'd4, acc);
    idle(12);
    cycle(1'b1, 16'h0001, 4'd1, acc);
    idle(8);

    // Six len-8 words with valid held high; FIFO fills and back-pressures.
    cnt   = 0;
    guard = 0;
    while (cnt < 6 && guard < 200) begin
      cycle(1'b1, 16'(16'h1100 * cnt + 16'h5A), 4'd8, acc);
      if (acc) cnt++;
      guard++;
    end
    check_val("burst_accepted", 32'(cnt), 32'd6);
    idle(80);

    // Two queued len-5 words separated by the gap.
    cycle(1'b1, 16'h0015, 4'd5, acc);
    cycle(1'b1, 16'h000A, 4'd5, acc);
    idle(20);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'b1 && ($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom), acc);
    idle(100);

    // Reset while bit 7 of a 16-bit word is on the line, two words queued.
    cycle(1'b1, 16'hC3A5, 4'd0, acc);
    base = nw - 1;
    cycle(1'b1, 16'h1234, 4'd3, acc);
    cycle(1'b1, 16'h4321, 4'd7, acc);
    guard = 0;
    while (cyc < w_s[base] + 8 && guard < 100) begin
      cycle(1'b0, 16'h0, 4'h0, acc);
      guard++;
    end
    check_val("reached_bit7", 32'(cyc), 32'(w_s[base] + 8));
    reset = 1'b1;
    #1;
    check_val("rst_ser_enable", 32'(bus.ser_enable), 32'd0);
    check_val("rst_ser_data",   32'(bus.ser_data),   32'd0);
    check_val("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check_val("rst_busy",       32'(bus.busy),       32'd0);
    check_val("rst_done",       32'(bus.done),       32'd0);
    check_val("rst_len_out",    32'(bus.len_out),    32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    check_cycle();
    idle(30);
    cycle(1'b1, 16'h00F0, 4'd8, acc);
    idle(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/p2s_framer.md
# p2s_framer

Parallel-to-serial framer feeding the `s2p` deserializer. It accepts 16-bit words with a per-word length through a valid/ready handshake and buffers them in a small FIFO. Each word goes out MSB-first as a one-bit stream qualified by `ser_enable`, with a guaranteed idle gap between words so the downstream `ready`/count logic re-arms. All outputs change on the rising edge, so the downstream negedge sampler always sees stable data.

## Interface
- `GAP`, default 1: idle cycles with `ser_enable` low between consecutive words. Legal range is 1 and up.
- `FIFO_DEPTH`, default 4: word buffer depth. Must be a power of 2, 2 or more.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_data`  in  16  word to send. Only bits [L-1:0] are transmitted.
- `in_len`  in  4  bit count L. Value 0 encodes 16; 1..15 are literal.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  FIFO not full. A word is accepted on a rising edge where `in_valid & in_ready`.
- `ser_data`  out  1  serial bit.
- `ser_enable`  out  1  high for exactly L cycles per word.
- `len_out`  out  4  `in_len` of the word in flight. Drives the downstream `len`. Stable from the first bit through the end of the gap.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.
- `done`  out  1  one-cycle pulse in the first gap cycle after a word's last bit.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- **IDLE**
  - If the FIFO is not empty: pop the head into `shreg[15:0]`, `len_out` and `bitcnt` (L, with 0 mapped to 16). Go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**
  - `ser_enable` = 1.
  - `ser_data` = `shreg[bitcnt-1]` (first bit is bit L-1, last is bit 0).
  - `bitcnt` decrements each cycle. At `bitcnt`==1, go to GAP with `gapcnt`=GAP.
- **GAP**
  - `ser_enable` = 0 and `ser_data` = 0. `done` = 1 in the first GAP cycle only.
  - `gapcnt` decrements. At `gapcnt`==1:
    - If the FIFO is not empty, pop directly and go to SHIFT.
    - Otherwise go to IDLE.
- Bit ordering matches a shift-left deserializer: the received value lands in `data_out[L-1:0]` and equals `in_data[L-1:0]`.
- `in_ready` = !full, from the registered FIFO count.
  - A push while full is impossible by construction.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
- Width rules:
  - `bitcnt` is 5 bits (holds 16).
  - `gapcnt` is sized by `$clog2(GAP+1)`.
  - FIFO pointers wrap modulo FIFO_DEPTH, with a count of log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - `in_ready`=1.
  - `ser_data`=0, `ser_enable`=0, `len_out`=0, `busy`=0, `done`=0.
  - FIFO empty, FSM in IDLE.
- Latency: a word accepted at edge k into an empty, idle block gets its first bit (`ser_enable` high) after edge k+1.
- Throughput: back-to-back words of length L occupy exactly L+GAP cycles each.
- `ser_enable` never stays high across a word boundary.
- Reset mid-word:
  - All outputs return to reset values immediately (asynchronous).
  - The partial word and all FIFO contents are discarded.
  - After release, the first output is the next word accepted.
- `in_len` is sampled only at acceptance. Later changes do not affect a buffered word.

## Structure
- Shared package `serial_pkg`:
  - `WORD_W`=16, `LEN_W`=4.
  - FSM state encoding.
  - A function mapping len to bit count (0 maps to 16).
  - Also used by `s2p` users.
- Sub-module `word_fifo`: synchronous FIFO, 20 bits wide ({len, data}), depth FIFO_DEPTH, asynchronous active-high reset, with `full`/`empty`/count outputs.
- `p2s_framer` contains the FSM, shift register and counters.

## Test plan
- Push 16'hA5C3 with len 0, then idle → `ser_enable` high for 16 cycles with bits 1010 0101 1100 0011. An attached `s2p` shows `data_out`=16'hA5C3 and `ready`=1. `done` pulses once.
- Push 16'hFFF9 with len 4 → 4 enabled cycles with bits 1,0,0,1. `len_out`=4. Downstream `data_out`[3:0]=4'h9.
- Push len 1, data 16'h0001 → exactly one enabled cycle with `ser_data`=1, then GAP low cycles.
- Hold `in_valid` high with 6 words of len 8, FIFO_DEPTH 4 → `in_ready` deasserts while full. All 6 words come out in order. Enable period is 8+GAP cycles with no loss or duplication.
- GAP=3 with two len-5 words queued → `ser_enable` is low for exactly 3 cycles between words, and `done` is high on the first of those 3.
- Assert `reset` during bit 7 of a 16-bit word with 2 words queued → `ser_enable`=0 immediately, `in_ready`=1, `busy`=0. After release, the output stays idle until a new push.
